// File: rtl/reg_file_neg_pkg.sv
// Shared definitions for the negative-edge register file: default geometry,
// the register word type and the byte-lane merge used by both the write path
// and the read-bypass path. Optional feature macro: RF_BYPASS_EN.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_LANES  = RF_DATA_W / 8;

    typedef logic [RF_DATA_W-1:0] word_t;
    typedef logic [RF_LANES-1:0]  lane_mask_t;

    // Take each byte lane from new_w where be is set, otherwise keep old_w.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                         input lane_mask_t be);
        word_t res;
        res = old_w;
        for (int i = 0; i < RF_LANES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_neg_read_port.sv
// One combinational read port: range check, hardwired-zero check and, when
// RF_BYPASS_EN is defined, forwarding of the in-flight write to the reader.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0]   regs_i [DEPTH],
    input  logic [ADDR_W-1:0]   raddr_i,
    input  logic                byp_en_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] rdata_s;
    logic              addr_ok_s;

    assign addr_ok_s = ({1'b0, raddr_i} < DEPTH_C) &&
                       !((ZERO_REG != 0) && (raddr_i == {ADDR_W{1'b0}}));

    // Select stored word (or forwarded write data) for a legal, non-zero address.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (addr_ok_s) begin
`ifdef RF_BYPASS_EN
            if (byp_en_i && (raddr_i == waddr_i)) begin
                rdata_s = byte_merge(regs_i[raddr_i], wdata_i, wbe_i);
            end else begin
                rdata_s = regs_i[raddr_i];
            end
`else
            rdata_s = regs_i[raddr_i];
`endif
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

`ifndef RF_BYPASS_EN
    // Write-side inputs only feed the forwarding mux.
    logic unused_byp_s;
    assign unused_byp_s = ^{byp_en_i, waddr_i, wdata_i, wbe_i};
`endif

    assign rdata_o = rdata_s;

endmodule

// File: rtl/reg_file_neg.sv
// DEPTH x DATA_W register file updated on the falling clock edge, with two
// combinational read ports, a byte-enabled write port and a one-deep shadow
// bank for trap save/restore. Optional feature macro: RF_BYPASS_EN (forward
// the pending write to matching read ports before the edge).
module reg_file_neg
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   raddr_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [DATA_W-1:0]   rdata_b,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                save,
    input  logic                restore,
    output logic                shadow_valid
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] main_q   [DEPTH];
    logic [DATA_W-1:0] main_d   [DEPTH];
    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic [DATA_W-1:0] shadow_d [DEPTH];
    logic              shadow_valid_q;
    logic              shadow_valid_d;
    logic              restore_hit_s;
    logic              write_ok_s;
    logic              byp_en_s;

    // A restore only counts when there is an image to restore.
    assign restore_hit_s = restore & shadow_valid_q;
    assign write_ok_s    = we & ({1'b0, waddr} < DEPTH_C) &
                           ~((ZERO_REG != 0) & (waddr == {ADDR_W{1'b0}})) &
                           (wbe != {(DATA_W/8){1'b0}});
    assign byp_en_s      = write_ok_s & ~restore_hit_s;

    // Next-state: a valid restore wins over save and write; save copies pre-edge main.
    always_comb begin
        main_d         = main_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (restore_hit_s) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((ZERO_REG != 0) && (k == 0)) begin
                    main_d[k] = {DATA_W{1'b0}};
                end else begin
                    main_d[k] = shadow_q[k];
                end
            end
            shadow_valid_d = 1'b0;
        end else begin
            if (save) begin
                shadow_d       = main_q;
                shadow_valid_d = 1'b1;
            end else begin
                shadow_d       = shadow_q;
                shadow_valid_d = shadow_valid_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (write_ok_s && (waddr == ADDR_W'(k))) begin
                    main_d[k] = byte_merge(main_q[k], wdata, wbe);
                end else begin
                    main_d[k] = main_q[k];
                end
            end
        end
    end

    // Falling-edge state update with asynchronous active-low clear.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                main_q[k]   <= {DATA_W{1'b0}};
                shadow_q[k] <= {DATA_W{1'b0}};
            end
            shadow_valid_q <= 1'b0;
        end else begin
            main_q         <= main_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    assign shadow_valid = shadow_valid_q;

    rf_read_port #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .regs_i(main_q), .raddr_i(raddr_a), .byp_en_i(byp_en_s),
        .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe), .rdata_o(rdata_a)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .regs_i(main_q), .raddr_i(raddr_b), .byp_en_i(byp_en_s),
        .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe), .rdata_o(rdata_b)
    );

endmodule

// File: tb/tb_reg_file_neg.sv
// Bench for reg_file_neg: two instances (ZERO_REG=0 and ZERO_REG=1, DEPTH=24)
// share one directed stimulus stream; a behavioural array model is compared
// every cycle, and hand-computed literals pin the model.
module tb_reg_file_neg;

    localparam int DW    = 32;
    localparam int DEPTH = 24;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] raddr_a = '0, raddr_b = '0, waddr = '0;
    logic          we = 1'b0, save = 1'b0, restore = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wbe = '0;
    logic [DW-1:0] ra0, rb0, ra1, rb1;
    logic          sv0, sv1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model: index 0 = ZERO_REG=0 instance, index 1 = ZERO_REG=1 instance
    logic [DW-1:0] mm [2][DEPTH];
    logic [DW-1:0] ss [2][DEPTH];
    bit            vv [2];

    reg_file_neg #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b),
        .rdata_b(rb0), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .save(save), .restore(restore), .shadow_valid(sv0));

    reg_file_neg #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b),
        .rdata_b(rb1), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .save(save), .restore(restore), .shadow_valid(sv1));

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit wr_legal(input int z);
        return we && (int'(waddr) < DEPTH) && !(z == 1 && waddr == 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        if (int'(a) >= DEPTH) return '0;
        if (z == 1 && a == 0) return '0;
        r = mm[z][a];
`ifdef RF_BYPASS_EN
        if (wr_legal(z) && a == waddr && !(restore && vv[z])) r = merge(r, wdata, wbe);
`endif
        return r;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // behavioural model update on the falling edge
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int z = 0; z < 2; z++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mm[z][k] <= '0;
                    ss[z][k] <= '0;
                end
                vv[z] <= 1'b0;
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (restore && vv[z]) begin
                    for (int k = 0; k < DEPTH; k++) mm[z][k] <= (z == 1 && k == 0) ? '0 : ss[z][k];
                    vv[z] <= 1'b0;
                end else begin
                    if (save) begin
                        for (int k = 0; k < DEPTH; k++) ss[z][k] <= mm[z][k];
                        vv[z] <= 1'b1;
                    end
                    if (wr_legal(z)) mm[z][waddr] <= merge(mm[z][waddr], wdata, wbe);
                end
            end
        end
    end

    // per-cycle compare, mid high phase
    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            check("cyc_a_z0", ra0, exp_rd(0, raddr_a));
            check("cyc_b_z0", rb0, exp_rd(0, raddr_b));
            check("cyc_a_z1", ra1, exp_rd(1, raddr_a));
            check("cyc_b_z1", rb1, exp_rd(1, raddr_b));
            check("cyc_sv_z0", {31'd0, sv0}, {31'd0, vv[0]});
            check("cyc_sv_z1", {31'd0, sv1}, {31'd0, vv[1]});
        end
    end

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic sa, input logic re,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        @(posedge clk);
        #1;
        we = w; waddr = wa; wdata = wd; wbe = be; save = sa; restore = re;
        raddr_a = a; raddr_b = b;
    endtask

    task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0, a, b);
        #2;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_a", ra1, 32'h0);
        check("rst_sv", {31'd0, sv1}, 32'h0);
        chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;

        // byte-lane write
        drive(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 5'd3, 5'd3);
        drive(1'b1, 5'd3, 32'h11223344, 4'h5, 1'b0, 1'b0, 5'd3, 5'd3);
        idle(5'd3, 5'd0);
        check("wr_lane_z1", ra1, 32'hDE22BE44);
        check("wr_lane_z0", ra0, 32'hDE22BE44);

        // hardwired zero register
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 5'd0, 5'd3);
        idle(5'd0, 5'd3);
        check("zero_z1", ra1, 32'h0);
        check("zero_z0", ra0, 32'hFFFFFFFF);

        // save with concurrent write, then restore
        drive(1'b1, 5'd5, 32'hA, 4'hF, 1'b0, 1'b0, 5'd5, 5'd5);
        drive(1'b1, 5'd5, 32'hB, 4'hF, 1'b1, 1'b0, 5'd5, 5'd5);
        #2 check("save_sv_pre", {31'd0, sv1}, 32'h0);
        drive(1'b1, 5'd5, 32'hC, 4'hF, 1'b0, 1'b0, 5'd5, 5'd5);
        #2 check("save_sv_set", {31'd0, sv1}, 32'h1);
        check("save_wr_main", ra1, 32'hB);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b1, 5'd5, 5'd5);
        #2 check("rest_pre", ra1, 32'hC);
        idle(5'd5, 5'd6);
        check("rest_val", ra1, 32'hA);
        check("rest_sv_clr", {31'd0, sv1}, 32'h0);

        // restore with concurrent write drops the write (and suppresses forwarding)
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0, 5'd6, 5'd5);
        drive(1'b1, 5'd6, 32'h77, 4'hF, 1'b0, 1'b1, 5'd6, 5'd5);
        #2 check("rest_wr_pre", ra1, 32'h0);
        idle(5'd6, 5'd5);
        check("rest_wr_drop", ra1, 32'h0);

        // restore without an image: write and save proceed
        drive(1'b1, 5'd7, 32'h55, 4'hF, 1'b1, 1'b1, 5'd7, 5'd7);
        idle(5'd7, 5'd5);
        check("rest_nv_wr", ra1, 32'h55);
        check("rest_nv_sv", {31'd0, sv1}, 32'h1);

        // forwarding
        drive(1'b1, 5'd9, 32'h12345678, 4'hF, 1'b0, 1'b0, 5'd9, 5'd9);
        drive(1'b1, 5'd9, 32'hAABBCCDD, 4'h3, 1'b0, 1'b0, 5'd9, 5'd9);
        #2;
`ifdef RF_BYPASS_EN
        check("byp_pre", ra1, 32'h1234CCDD);
`else
        check("byp_pre", ra1, 32'h12345678);
`endif
        idle(5'd9, 5'd9);
        check("byp_post", ra1, 32'h1234CCDD);

        // empty byte mask, out-of-range and last register
        drive(1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 5'd3, 5'd3);
        drive(1'b1, 5'd30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 5'd30, 5'd30);
        drive(1'b1, 5'd23, 32'h13579BDF, 4'hF, 1'b0, 1'b0, 5'd23, 5'd3);
        idle(5'd30, 5'd23);
        check("oor_rd", ra1, 32'h0);
        check("last_reg", rb1, 32'h13579BDF);
        idle(5'd3, 5'd3);
        check("wbe0_hold", ra1, 32'hDE22BE44);

        // asynchronous reset mid-operation aborts the pending write
        drive(1'b1, 5'd3, 32'h0, 4'hF, 1'b1, 1'b0, 5'd3, 5'd9);
        #1 rst = 1'b0;
        #1;
        check("arst_a", ra1, 32'h0);
        check("arst_b", rb0, 32'h0);
        check("arst_sv", {31'd0, sv1}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        idle(5'd3, 5'd7);
        check("arst_hold", ra1, 32'h0);

        idle(5'd0, 5'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_neg.md
Name: reg_file_neg

Overview:
- Parametrised multi-register storage block: a DEPTH x DATA_W register file.
- Two combinational read ports and one byte-enabled write port.
- All state updates on the negative edge of clk, so writes settle mid-cycle for the single-cycle datapath.
- Adds a one-deep shadow bank (save/restore) for trap entry/return, and optional hardwired-zero register 0.

Parameters:
DATA_W, 32, register width in bits; multiple of 8
DEPTH, 32, number of registers
ADDR_W, 5, address width; DEPTH <= 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/restore

Ports:
clk  input  1  clock; all state changes on falling edge
rst  input  1  asynchronous reset, active-low (0 = reset)
raddr_a  input  ADDR_W  read port A address
rdata_a  output  DATA_W  read port A data, combinational
raddr_b  input  ADDR_W  read port B address
rdata_b  output  DATA_W  read port B data, combinational
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
wbe  input  DATA_W/8  byte-lane write enables
save  input  1  copy whole main bank to shadow bank
restore  input  1  copy shadow bank back to main bank
shadow_valid  output  1  shadow bank holds a saved image

Behaviour:
- Reset (rst=0, asynchronous, no clk needed): all main and shadow registers = 0; shadow_valid = 0. Reset asserted mid-operation aborts any pending write/save/restore. Release is synchronised by the integrator.
- Reads: rdata_x = main[raddr_x], zero latency. raddr_x >= DEPTH reads 0. ZERO_REG=1 and raddr_x = 0 reads 0.
- Write, at negedge with we=1, waddr < DEPTH, and not (ZERO_REG and waddr=0): for each lane i with wbe[i]=1, main[waddr][8i+7:8i] <= wdata lane i. Other lanes hold.
- Ignored writes: wbe = 0 performs no write; out-of-range waddr is ignored.
- Save, at negedge with save=1, restore=0: shadow[k] <= main[k] for all k, using pre-edge values; shadow_valid <= 1. A write in the same edge still updates main, but the shadow gets the old value.
- Restore, at negedge with restore=1 and shadow_valid=1: main[k] <= shadow[k] for all k; shadow_valid <= 0. Any same-edge write is dropped; any same-edge save is ignored. With ZERO_REG=1, main[0] stays 0.
- Restore with shadow_valid=0 is a no-op; a same-edge write and save then proceed normally.
- Priority per edge: reset > restore(valid) > save + write.
- Repeated save overwrites the shadow image; shadow_valid stays 1.
- Without bypass, a read of the register being written returns the old value until the falling edge, then the new value.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when we=1 and raddr_x = waddr (valid, non-zero per ZERO_REG), rdata_x returns the byte-merge of wdata (enabled lanes) and main[waddr] (disabled lanes) combinationally before the edge. Not applied in an edge where a valid restore is asserted.
- Undefined: reads return stored contents only.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W / ADDR_W / DEPTH constants
  - LANES = DATA_W/8
  - typedef for a register word
  - function byte_merge(old, new, be), shared by the write path and the bypass path
- Natural sub-module: rf_read_port (address decode, range/zero check, optional bypass mux), instantiated twice.

Test Plan:
- Reset: rst=0 with prior data loaded -> rdata_a=rdata_b=0 immediately, shadow_valid=0, no clock edge required.
- Write: we=1, waddr=3, wdata=0xDEADBEEF, wbe=0xF, then waddr=3, wdata=0x11223344, wbe=0x5 -> after the second negedge, r3 reads 0xDE22BE44.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 -> rdata=0. Same write with ZERO_REG=0 -> 0xFFFFFFFF.
- Save with concurrent write: r5=0xA, save=1 together with a write of 0xB to r5; then write r5=0xC, then restore -> r5 reads 0xA, shadow_valid goes 1 then 0.
- Restore with concurrent write: restore + write in the same edge -> write dropped. Restore with shadow_valid=0 alongside we=1, r7=0x55 -> r7=0x55, no restore.
- Bypass (RF_BYPASS_EN): r9=0x12345678, we=1, waddr=raddr_a=9, wdata=0xAABBCCDD, wbe=0x3 -> rdata_a=0x1234CCDD before the negedge. Without the macro -> 0x12345678 before the edge, 0x1234CCDD after.
